nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
Parametrised master sequencer for the CORDIC MAC inference datapath. It walks a network of up to MAX_LAYERS dense layers neuron by neuron. For each neuron it runs a weight/bias load, a MAC, an activation and a result write, and between layers it swaps the ping-pong output buffer. Compared with the earlier fixed controller it adds parametric depth, widths and latencies, a memory-ready stall, a synchronous abort, configuration checking and a proper start/busy/done handshake.

Parameters:
MAX_LAYERS, 8, maximum number of weight layers (>=1)
NW, 6, width of a per-layer neuron count
LW, 3, width of the layer index, equal to clog2(MAX_LAYERS) with a minimum of 1
MAC_LAT, 10, cycles compute_en is held per neuron (>=1)
AF_LAT, 32, cycles af_en is held per neuron (0 = AF phase skipped)
LOAD_PAD, 2, extra accepted load beats after the last input (pipeline fill of the weight/bias ROMs)

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin run; sampled only in IDLE or DONE
abort  in  1  synchronous abort; forces IDLE next cycle from any state
num_layers  in  LW+1  number of weight layers L, valid range 1..MAX_LAYERS
layer_size  in  (MAX_LAYERS+1)*NW  flattened sizes; slice k = neurons in layer k, slice 0 = input width
mem_ready  in  1  weight/bias memory can accept a beat this cycle
weight_en  out  1  weight fetch enable
bias_en  out  1  bias fetch enable
bias_sel  out  1  0 for neuron 0 of a layer, 1 otherwise
compute_en  out  1  CORDIC MAC enable
af_en  out  1  activation unit enable
output_wr_en  out  1  1-cycle pulse; write neuron result
output_shft_en  out  1  1-cycle pulse; swap output buffers at end of layer
output_sel  out  1  0 while layer 0 is active (inputs from input RAM), 1 otherwise
layer_idx  out  LW  current layer l
neuron_idx  out  NW  current output neuron j
in_idx  out  NW  accepted input beat index within LOAD
busy  out  1  high from LOAD through NEXT
done  out  1  1-cycle pulse when entering DONE
tot_complete  out  1  level; high in DONE until the next start or rst
cfg_err  out  1  level; set on a rejected start, cleared by the next accepted start

Behaviour:
- Reset: all outputs are 0, every counter is 0, state is IDLE.
- Configuration: num_layers and layer_size are registered on an accepted start and ignored afterwards.
- Start rejection: if L==0, L>MAX_LAYERS, or any size[0..L]==0, start is rejected. cfg_err=1, state stays in or returns to IDLE, busy stays 0.
- States: IDLE, LOAD, MAC, AF, WRITE, NEXT, DONE.
- IDLE/DONE + valid start -> LOAD. Clear l, j, in_idx and tot_complete.
- LOAD:
  - weight_en = bias_en = mem_ready.
  - A beat counts only when mem_ready=1.
  - in_idx increments per beat up to size[l]-1, then holds.
  - After size[l]+LOAD_PAD beats -> MAC.
  - mem_ready=0 stalls the phase indefinitely; no other output changes during the stall.
- MAC: compute_en=1 for exactly MAC_LAT cycles, then -> AF, or -> WRITE when AF_LAT==0.
- AF: compute_en=1 and af_en=1 for exactly AF_LAT cycles, then -> WRITE.
- WRITE:
  - output_wr_en=1 for one cycle.
  - If j < size[l+1]-1: j++, in_idx=0, -> LOAD.
  - Otherwise -> NEXT.
- NEXT:
  - output_shft_en=1 for one cycle, j=0, in_idx=0.
  - If l == L-1: -> DONE with done pulse; l holds at L-1.
  - Otherwise: l++, -> LOAD.
- Combinational outputs: bias_sel = (j!=0); output_sel = (l!=0).
- Counters are sized so that the max latency and max size fit; there is no wrap inside a phase.
- Abort has priority over every transition, including a simultaneous start. Reset behaviour applies except that cfg_err and tot_complete hold their values.
- start asserted while busy is ignored.

Decomposition:
- Shared package nn_ctrl_pkg: the state encoding enum, phase latency defaults, and a layer_size slice-extraction function.
- One sub-module, nn_phase_counter: a loadable down-counter with an enable/stall input and a zero flag. It is reused for the LOAD, MAC and AF phases.

Test Plan:
- MAX_LAYERS=4, L=2, sizes {2,3,1}, LOAD_PAD=2, MAC_LAT=10, AF_LAT=32, mem_ready=1 -> 4 output_wr_en pulses and 2 output_shft_en pulses; done exactly 191 cycles after weight_en first rises.
- Same config with mem_ready low for 5 cycles mid-LOAD -> done delayed by exactly 5 cycles; in_idx frozen during the stall.
- AF_LAT=0, L=1, sizes {1,1} -> af_en never asserts; sequence is LOAD 3 cycles, MAC 10, WRITE 1, NEXT 1; done at cycle 15.
- start with sizes {2,0,1} or with num_layers=0 -> cfg_err=1, busy stays 0, no enables assert.
- abort asserted in cycle 20 of the first run -> all enables 0 the next cycle, state IDLE; a following start reruns the full first test with identical timing.
- rst asserted mid-AF (asynchronous, between clock edges) -> every output is 0 immediately; tot_complete=0.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the layer sequencer: state encoding,
// default phase latencies and flattened layer-size slice extraction.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_AF    = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } nn_state_e;

  localparam int unsigned DEF_MAC_LAT  = 10;
  localparam int unsigned DEF_AF_LAT   = 32;
  localparam int unsigned DEF_LOAD_PAD = 2;

  // Upper bound on the flattened size vector; callers zero-extend into it.
  localparam int unsigned SIZES_MAX_W = 512;

  function automatic int unsigned size_at(input logic [SIZES_MAX_W-1:0] sizes,
                                          input int unsigned k,
                                          input int unsigned nw);
    logic [31:0] v;
    v = 32'(sizes >> (k * nw));
    return v & ((32'd1 << nw) - 32'd1);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control/status bundle between the host and the layer sequencer.
interface nn_layer_sequencer_if #(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned NW         = 6,
  parameter int unsigned LW         = 3
);
  logic                           start;
  logic                           abort;
  logic [LW:0]                    num_layers;
  logic [(MAX_LAYERS+1)*NW-1:0]   layer_size;
  logic                           mem_ready;

  logic                           weight_en;
  logic                           bias_en;
  logic                           bias_sel;
  logic                           compute_en;
  logic                           af_en;
  logic                           output_wr_en;
  logic                           output_shft_en;
  logic                           output_sel;
  logic [LW-1:0]                  layer_idx;
  logic [NW-1:0]                  neuron_idx;
  logic [NW-1:0]                  in_idx;
  logic                           busy;
  logic                           done;
  logic                           tot_complete;
  logic                           cfg_err;

  modport master (
    output start, abort, num_layers, layer_size, mem_ready,
    input  weight_en, bias_en, bias_sel, compute_en, af_en, output_wr_en,
           output_shft_en, output_sel, layer_idx, neuron_idx, in_idx,
           busy, done, tot_complete, cfg_err
  );

  modport slave (
    input  start, abort, num_layers, layer_size, mem_ready,
    output weight_en, bias_en, bias_sel, compute_en, af_en, output_wr_en,
           output_shft_en, output_sel, layer_idx, neuron_idx, in_idx,
           busy, done, tot_complete, cfg_err
  );
endinterface

// File: rtl/nn_phase_counter.sv
// Loadable down-counter with stall enable and zero flag; shared by the
// LOAD, MAC and AF phases of the sequencer.
module nn_phase_counter #(
  parameter int unsigned CW = 8
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  input  logic          i_en,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_load)               r_cnt <= i_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - CW'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/nn_layer_sequencer.sv
// Master sequencer for the CORDIC MAC datapath: walks layers and neurons
// through LOAD/MAC/AF/WRITE and swaps the output buffer between layers.
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned NW         = 6,
  parameter int unsigned LW         = 3,
  parameter int unsigned MAC_LAT    = DEF_MAC_LAT,
  parameter int unsigned AF_LAT     = DEF_AF_LAT,
  parameter int unsigned LOAD_PAD   = DEF_LOAD_PAD
)(
  input logic               clk,
  input logic               rst,
  nn_layer_sequencer_if.slave bus
);
  localparam int unsigned SW       = (MAX_LAYERS + 1) * NW;
  localparam int unsigned CNT_MAX  = max3((32'd1 << NW) - 32'd1 + LOAD_PAD, MAC_LAT, AF_LAT);
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned MAC_LOAD = MAC_LAT - 1;
  localparam int unsigned AF_LOAD  = (AF_LAT == 0) ? 0 : AF_LAT - 1;

  nn_state_e     r_state;
  logic [LW-1:0] r_l;
  logic [NW-1:0] r_j;
  logic [NW-1:0] r_in_idx;
  logic [LW:0]   r_layers;
  logic [SW-1:0] r_sizes;
  logic          r_compute_en, r_af_en, r_wr_en, r_shft_en;
  logic          r_busy, r_done, r_tot, r_cfg_err;

  logic          w_cfg_ok;
  logic          w_beat;
  logic          w_cnt_zero, w_cnt_load, w_cnt_en;
  logic [CW-1:0] w_cnt_val;
  logic [NW-1:0] w_size_cur, w_size_nxt;
  logic          w_last_in, w_last_neuron, w_last_layer;

  assign w_size_cur    = NW'(size_at(SIZES_MAX_W'(r_sizes), 32'(r_l), NW));
  assign w_size_nxt    = NW'(size_at(SIZES_MAX_W'(r_sizes), 32'(r_l) + 32'd1, NW));
  assign w_last_in     = (r_in_idx == w_size_cur - NW'(1));
  assign w_last_neuron = (r_j == w_size_nxt - NW'(1));
  assign w_last_layer  = ((LW+1)'(r_l) == r_layers - (LW+1)'(1));
  assign w_beat        = (r_state == S_LOAD) && bus.mem_ready;

  // Every size from the input width up to the last layer must be non-zero.
  always_comb begin
    w_cfg_ok = (bus.num_layers != '0) && (bus.num_layers <= (LW+1)'(MAX_LAYERS));
    for (int unsigned k = 0; k <= MAX_LAYERS; k++) begin
      if (((LW+1)'(k) <= bus.num_layers) &&
          (size_at(SIZES_MAX_W'(bus.layer_size), k, NW) == 32'd0))
        w_cfg_ok = 1'b0;
    end
  end

  // Phase counter is loaded with (phase length - 1) on entry to each phase.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_cnt_load = bus.start && w_cfg_ok;
        w_cnt_val  = CW'(size_at(SIZES_MAX_W'(bus.layer_size), 32'd0, NW) + LOAD_PAD - 32'd1);
      end
      S_LOAD: begin
        w_cnt_en   = bus.mem_ready;
        w_cnt_load = bus.mem_ready && w_cnt_zero;
        w_cnt_val  = CW'(MAC_LOAD);
      end
      S_MAC: begin
        w_cnt_en   = 1'b1;
        w_cnt_load = w_cnt_zero;
        w_cnt_val  = CW'(AF_LOAD);
      end
      S_AF:    w_cnt_en = 1'b1;
      S_WRITE: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = CW'(32'(w_size_cur) + LOAD_PAD - 32'd1);
      end
      S_NEXT: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = CW'(32'(w_size_nxt) + LOAD_PAD - 32'd1);
      end
      default: ;
    endcase
  end

  nn_phase_counter #(.CW(CW)) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (bus.abort),
    .i_load (w_cnt_load),
    .i_val  (w_cnt_val),
    .i_en   (w_cnt_en),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_l          <= '0;
      r_j          <= '0;
      r_in_idx     <= '0;
      r_layers     <= '0;
      r_sizes      <= '0;
      r_compute_en <= 1'b0;
      r_af_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_shft_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tot        <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else if (bus.abort) begin
      // Abort behaves like reset but keeps the sticky status levels.
      r_state      <= S_IDLE;
      r_l          <= '0;
      r_j          <= '0;
      r_in_idx     <= '0;
      r_compute_en <= 1'b0;
      r_af_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_shft_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_shft_en <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_tot <= 1'b0;
            if (w_cfg_ok) begin
              r_layers  <= bus.num_layers;
              r_sizes   <= bus.layer_size;
              r_l       <= '0;
              r_j       <= '0;
              r_in_idx  <= '0;
              r_cfg_err <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_LOAD;
            end else begin
              r_cfg_err <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        S_LOAD: begin
          if (bus.mem_ready) begin
            if (!w_last_in) r_in_idx <= r_in_idx + NW'(1);
            if (w_cnt_zero) begin
              r_compute_en <= 1'b1;
              r_state      <= S_MAC;
            end
          end
        end
        S_MAC: begin
          if (w_cnt_zero) begin
            if (AF_LAT == 0) begin
              r_compute_en <= 1'b0;
              r_wr_en      <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              r_af_en <= 1'b1;
              r_state <= S_AF;
            end
          end
        end
        S_AF: begin
          if (w_cnt_zero) begin
            r_compute_en <= 1'b0;
            r_af_en      <= 1'b0;
            r_wr_en      <= 1'b1;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_in_idx <= '0;
          if (!w_last_neuron) begin
            r_j     <= r_j + NW'(1);
            r_state <= S_LOAD;
          end else begin
            r_j       <= '0;
            r_shft_en <= 1'b1;
            r_state   <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last_layer) begin
            r_done  <= 1'b1;
            r_tot   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_l     <= r_l + LW'(1);
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.weight_en      = w_beat;
  assign bus.bias_en        = w_beat;
  assign bus.bias_sel       = (r_j != '0);
  assign bus.output_sel     = (r_l != '0);
  assign bus.compute_en     = r_compute_en;
  assign bus.af_en          = r_af_en;
  assign bus.output_wr_en   = r_wr_en;
  assign bus.output_shft_en = r_shft_en;
  assign bus.layer_idx      = r_l;
  assign bus.neuron_idx     = r_j;
  assign bus.in_idx         = r_in_idx;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.tot_complete   = r_tot;
  assign bus.cfg_err        = r_cfg_err;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: a full-latency instance and an
// AF-skipping instance, both with MAX_LAYERS=4.
module tb_nn_layer_sequencer;
  localparam int unsigned ML = 4;
  localparam int unsigned NW = 6;
  localparam int unsigned LW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_layer_sequencer_if #(.MAX_LAYERS(ML), .NW(NW), .LW(LW)) if_a ();
  nn_layer_sequencer_if #(.MAX_LAYERS(ML), .NW(NW), .LW(LW)) if_b ();

  nn_layer_sequencer #(.MAX_LAYERS(ML), .NW(NW), .LW(LW),
                       .MAC_LAT(10), .AF_LAT(32), .LOAD_PAD(2)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));

  nn_layer_sequencer #(.MAX_LAYERS(ML), .NW(NW), .LW(LW),
                       .MAC_LAT(10), .AF_LAT(0), .LOAD_PAD(2)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  int checks   = 0;
  int failures = 0;

  function automatic logic [29:0] pack3(input int s0, input int s1, input int s2);
    return {12'd0, 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  function automatic logic [15:0] outs_a();
    return {if_a.weight_en, if_a.bias_en, if_a.bias_sel, if_a.compute_en, if_a.af_en,
            if_a.output_wr_en, if_a.output_shft_en, if_a.output_sel, if_a.busy,
            if_a.done, if_a.tot_complete, if_a.cfg_err, if_a.layer_idx, if_a.in_idx[1:0]};
  endfunction

  task automatic start_pulse_a();
    @(posedge clk); #1;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
  endtask

  // Runs dut_a from a start pulse; optional mem_ready stall from cycle stall_at.
  task automatic run_a(input int stall_at, input int stall_len, output int t_done,
                       output int n_wr, output int n_shft, output int n_stall_bad,
                       output logic [4:0] first);
    t_done = -1; n_wr = 0; n_shft = 0; n_stall_bad = 0; first = '0;
    start_pulse_a();
    for (int c = 0; c < 400; c++) begin
      if (c == 0) first = {if_a.weight_en, if_a.bias_en, if_a.busy, if_a.output_sel, if_a.bias_sel};
      if (if_a.output_wr_en) n_wr++;
      if (if_a.output_shft_en) n_shft++;
      if (c > stall_at && c <= stall_at + stall_len &&
          (if_a.in_idx !== 6'd1 || if_a.weight_en !== 1'b0)) n_stall_bad++;
      if (if_a.done) begin t_done = c; break; end
      if (c == stall_at) if_a.mem_ready = 1'b0;
      if (c == stall_at + stall_len) if_a.mem_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] oa, ob;
    rst = 1'b0;
    {if_a.start, if_a.abort, if_b.start, if_b.abort} = '0;
    if_a.mem_ready = 1'b1; if_b.mem_ready = 1'b1;
    if_a.num_layers = 3'd2; if_a.layer_size = pack3(2, 3, 1);
    if_b.num_layers = 3'd1; if_b.layer_size = pack3(1, 1, 0);
    #2 rst = 1'b1;
    #1;
    oa = outs_a();
    ob = {if_b.weight_en, if_b.compute_en, if_b.af_en, if_b.busy, if_b.done,
          if_b.tot_complete, if_b.cfg_err, if_b.output_wr_en, 8'd0};
    checks++;
    if (oa !== 16'd0) begin failures++; $display("FAIL reset_a: got %h want 0000", oa); end
    checks++;
    if (ob !== 16'd0) begin failures++; $display("FAIL reset_b: got %h want 0000", ob); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_af_skip();
    int n_af = 0, n_comp = 0, n_we = 0, t_c0 = -1, t_wr = -1, t_sh = -1, t_dn = -1;
    @(posedge clk); #1 if_b.start = 1'b1;
    @(posedge clk); #1 if_b.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (if_b.af_en) n_af++;
      if (if_b.weight_en) n_we++;
      if (if_b.compute_en) begin n_comp++; if (t_c0 < 0) t_c0 = c; end
      if (if_b.output_wr_en) t_wr = c;
      if (if_b.output_shft_en) t_sh = c;
      if (if_b.done) begin t_dn = c; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (n_af !== 0) begin failures++; $display("FAIL afskip_af_en: got %0d cycles want 0", n_af); end
    checks++;
    if ({n_we, n_comp, t_c0} !== {32'd3, 32'd10, 32'd3})
      begin failures++; $display("FAIL afskip_load_mac: got load=%0d mac=%0d mac_start=%0d want 3 10 3", n_we, n_comp, t_c0); end
    checks++;
    if ({t_wr, t_sh, t_dn} !== {32'd13, 32'd14, 32'd15})
      begin failures++; $display("FAIL afskip_timing: got wr=%0d shft=%0d done=%0d want 13 14 15", t_wr, t_sh, t_dn); end
  endtask

  task automatic test_full_run();
    int t, nw, ns, nb;
    logic [4:0] f;
    run_a(-1, 0, t, nw, ns, nb, f);
    checks++;
    if (f !== 5'b11100) begin failures++; $display("FAIL run_first_cycle: got %b want 11100", f); end
    checks++;
    if (t !== 191) begin failures++; $display("FAIL run_done_time: got %0d want 191", t); end
    checks++;
    if (nw !== 4 || ns !== 2) begin failures++; $display("FAIL run_pulses: got wr=%0d shft=%0d want 4 2", nw, ns); end
    checks++;
    if ({if_a.busy, if_a.tot_complete, if_a.layer_idx} !== 4'b0101)
      begin failures++; $display("FAIL run_done_state: got %b want 0101", {if_a.busy, if_a.tot_complete, if_a.layer_idx}); end
    @(posedge clk); #1;
    checks++;
    if ({if_a.done, if_a.tot_complete} !== 2'b01)
      begin failures++; $display("FAIL run_done_pulse: got %b want 01", {if_a.done, if_a.tot_complete}); end
  endtask

  task automatic test_stall();
    int t, nw, ns, nb;
    logic [4:0] f;
    run_a(48, 5, t, nw, ns, nb, f);
    checks++;
    if (t !== 196) begin failures++; $display("FAIL stall_done_time: got %0d want 196", t); end
    checks++;
    if (nb !== 0) begin failures++; $display("FAIL stall_frozen: got %0d bad cycles want 0", nb); end
    checks++;
    if (nw !== 4) begin failures++; $display("FAIL stall_wr_count: got %0d want 4", nw); end
  endtask

  task automatic test_cfg_err();
    int nbad = 0;
    if_a.num_layers = 3'd2; if_a.layer_size = pack3(2, 0, 1);
    start_pulse_a();
    checks++;
    if ({if_a.cfg_err, if_a.busy} !== 2'b10)
      begin failures++; $display("FAIL cfg_zero_size: got %b want 10", {if_a.cfg_err, if_a.busy}); end
    if_a.layer_size = pack3(2, 3, 1);
    start_pulse_a();
    checks++;
    if ({if_a.cfg_err, if_a.busy} !== 2'b01)
      begin failures++; $display("FAIL cfg_clear: got %b want 01", {if_a.cfg_err, if_a.busy}); end
    if_a.abort = 1'b1;
    @(posedge clk); #1 if_a.abort = 1'b0;
    if_a.num_layers = 3'd0;
    start_pulse_a();
    checks++;
    if ({if_a.cfg_err, if_a.busy} !== 2'b10)
      begin failures++; $display("FAIL cfg_zero_layers: got %b want 10", {if_a.cfg_err, if_a.busy}); end
    for (int c = 0; c < 5; c++) begin
      if (if_a.weight_en || if_a.compute_en || if_a.af_en || if_a.busy) nbad++;
      @(posedge clk); #1;
    end
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL cfg_no_enables: got %0d active cycles want 0", nbad); end
    if_a.num_layers = 3'd2;
  endtask

  task automatic test_abort();
    int t, nw, ns, nb;
    logic [4:0] f;
    start_pulse_a();
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    if_a.abort = 1'b1;
    @(posedge clk); #1 if_a.abort = 1'b0;
    checks++;
    if (outs_a() !== 16'd0) begin failures++; $display("FAIL abort_outputs: got %h want 0000", outs_a()); end
    run_a(-1, 0, t, nw, ns, nb, f);
    checks++;
    if (t !== 191 || nw !== 4 || ns !== 2)
      begin failures++; $display("FAIL abort_rerun: got done=%0d wr=%0d shft=%0d want 191 4 2", t, nw, ns); end
    // Abort wins over a simultaneous start and keeps tot_complete.
    if_a.abort = 1'b1; if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.abort = 1'b0; if_a.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({if_a.busy, if_a.weight_en, if_a.tot_complete} !== 3'b001)
      begin failures++; $display("FAIL abort_vs_start: got %b want 001", {if_a.busy, if_a.weight_en, if_a.tot_complete}); end
  endtask

  task automatic test_async_reset();
    start_pulse_a();
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    checks++;
    if ({if_a.compute_en, if_a.af_en} !== 2'b11)
      begin failures++; $display("FAIL rst_in_af: got %b want 11", {if_a.compute_en, if_a.af_en}); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs_a() !== 16'd0) begin failures++; $display("FAIL rst_async_outputs: got %h want 0000", outs_a()); end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_af_skip();
    test_full_run();
    test_stall();
    test_cfg_err();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
